// File: rtl/shift_sequencer.sv
// Command sequencer for an 8-bit universal shift register (l/r/d/i -> q).
// Steps the register once per rising edge; pin drives are re-timed to the falling edge.
module shift_sequencer #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          c,
  input  logic          nrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_fill,
  input  logic [W-1:0]  sr_q,
  output logic [W-1:0]  sr_d,
  output logic          sr_i,
  output logic          sr_l,
  output logic          sr_r,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // state  | meaning
  // IDLE   | ready for a command, register held
  // RUN    | one register step per rising edge, cnt steps remaining
  // DONE   | one-cycle completion pulse, err valid

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic          fill_q, fill_d;
  logic          err_q, err_d;

  logic [W-1:0]  sr_d_q, sr_d_d;
  logic          sr_i_q, sr_i_d;
  logic          sr_l_q, sr_l_d;
  logic          sr_r_q, sr_r_d;

  logic          accept;
  logic          op_legal;
  logic          unused_sr_q;

  assign accept      = (state_q == S_IDLE) && cmd_valid;
  assign op_legal    = (cmd_op <= OP_ASR);
  assign unused_sr_q = ^sr_q[W-2:1];

  // State register and command latch
  always_ff @(posedge c or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!op_legal)
            state_d = S_DONE;
          else if (cmd_op == OP_LOAD)
            state_d = S_RUN;
          else if (cmd_amt == '0)
            state_d = S_DONE;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        // cnt of 0 cannot occur in RUN; treating it as last step avoids a lock-up
        if (cnt_q <= AW'(1))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch and step counter
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    data_d = data_q;
    fill_d = fill_q;
    err_d  = err_q;
    if (accept) begin
      op_d   = cmd_op;
      data_d = cmd_data;
      fill_d = cmd_fill;
      err_d  = !op_legal;
      if (!op_legal)
        cnt_d = '0;
      else if (cmd_op == OP_LOAD)
        cnt_d = AW'(1);
      else
        cnt_d = cmd_amt;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - AW'(1);
    end
  end

  // Register pin drives; rotate/arithmetic fill comes from the previous step's q
  always_comb begin
    sr_l_d = 1'b0;
    sr_r_d = 1'b0;
    sr_i_d = sr_i_q;
    sr_d_d = sr_d_q;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_LOAD: begin
          sr_l_d = 1'b1;
          sr_r_d = 1'b1;
          sr_d_d = data_q;
        end
        OP_SHL: begin
          sr_r_d = 1'b1;
          sr_i_d = fill_q;
        end
        OP_SHR: begin
          sr_l_d = 1'b1;
          sr_i_d = fill_q;
        end
        OP_ROL: begin
          sr_r_d = 1'b1;
          sr_i_d = sr_q[W-1];
        end
        OP_ROR: begin
          sr_l_d = 1'b1;
          sr_i_d = sr_q[0];
        end
        OP_ASR: begin
          sr_l_d = 1'b1;
          sr_i_d = sr_q[W-1];
        end
        default: begin
          sr_l_d = 1'b0;
          sr_r_d = 1'b0;
        end
      endcase
    end
  end

  // Falling-edge re-timing keeps l/r stable while c is high (register gates with (l|r)&c)
  always_ff @(negedge c or negedge nrst) begin
    if (!nrst) begin
      sr_d_q <= '0;
      sr_i_q <= 1'b0;
      sr_l_q <= 1'b0;
      sr_r_q <= 1'b0;
    end else begin
      sr_d_q <= sr_d_d;
      sr_i_q <= sr_i_d;
      sr_l_q <= sr_l_d;
      sr_r_q <= sr_r_d;
    end
  end

  assign sr_d      = sr_d_q;
  assign sr_i      = sr_i_q;
  assign sr_l      = sr_l_q;
  assign sr_r      = sr_r_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign cmd_ready = (state_q == S_IDLE) && nrst;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with a behavioural gated-clock universal shift register.
module tb_shift_sequencer;

  logic       c = 1'b0;
  logic       nrst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_amt = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_fill = 1'b0;
  logic [7:0] sr_q = 8'h00;
  logic [7:0] sr_d;
  logic       sr_i, sr_l, sr_r;
  logic       busy, done, err;

  int n_cmp  = 0;
  int n_fail = 0;
  int gc_viol = 0;

  shift_sequencer #(.W(8), .AW(3)) dut (
    .c(c), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .sr_q(sr_q), .sr_d(sr_d), .sr_i(sr_i), .sr_l(sr_l), .sr_r(sr_r),
    .busy(busy), .done(done), .err(err)
  );

  initial forever #5 c = ~c;

  // Shift register model, clock gated by (l|r)&c
  wire gclk = (sr_l | sr_r) & c;
  always @(posedge gclk) begin
    if (sr_l && sr_r)  sr_q <= sr_d;
    else if (sr_l)     sr_q <= {sr_i, sr_q[7:1]};
    else if (sr_r)     sr_q <= {sr_q[6:0], sr_i};
  end

  always @(sr_l or sr_r) begin
    if (nrst && c) gc_viol++;
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic       fill;
    logic [7:0] exp_q;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int tmo;
    int lat;
    tmo = 0;
    @(negedge c);
    while (!cmd_ready && tmo < 50) begin
      @(negedge c);
      tmo++;
    end
    check($sformatf("v%0d_ready_wait", idx), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_amt   = v.amt;
    cmd_data  = v.data;
    cmd_fill  = v.fill;
    @(posedge c); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge c); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_q", idx), {24'd0, sr_q}, {24'd0, v.exp_q});
    check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
    check($sformatf("v%0d_ready_in_done", idx), {31'd0, cmd_ready}, 32'd0);
    @(posedge c); #1;
    check($sformatf("v%0d_done_ready_after", idx), {30'd0, done, cmd_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{3'd0, 3'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1};
    vecs[1]  = '{3'd1, 3'd3, 8'h00, 1'b1, 8'h2F, 1'b0, 3};
    vecs[2]  = '{3'd0, 3'd5, 8'hA5, 1'b0, 8'hA5, 1'b0, 1};
    vecs[3]  = '{3'd4, 3'd4, 8'h00, 1'b0, 8'h5A, 1'b0, 4};
    vecs[4]  = '{3'd0, 3'd0, 8'h80, 1'b0, 8'h80, 1'b0, 1};
    vecs[5]  = '{3'd3, 3'd1, 8'h00, 1'b0, 8'h01, 1'b0, 1};
    vecs[6]  = '{3'd0, 3'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1};
    vecs[7]  = '{3'd5, 3'd2, 8'h00, 1'b0, 8'hE9, 1'b0, 2};
    vecs[8]  = '{3'd2, 3'd0, 8'h00, 1'b1, 8'hE9, 1'b0, 0};
    vecs[9]  = '{3'd7, 3'd3, 8'h12, 1'b1, 8'hE9, 1'b1, 0};
    vecs[10] = '{3'd0, 3'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, 1};
    vecs[11] = '{3'd2, 3'd2, 8'h00, 1'b1, 8'hCF, 1'b0, 2};
    vecs[12] = '{3'd3, 3'd7, 8'h00, 1'b0, 8'hE7, 1'b0, 7};
    vecs[13] = '{3'd6, 3'd0, 8'h00, 1'b0, 8'hE7, 1'b1, 0};
    vecs[14] = '{3'd1, 3'd1, 8'h00, 1'b0, 8'hCE, 1'b0, 1};

    #2 nrst = 1'b0;
    #1;
    check("rst_status", {28'd0, busy, done, err, cmd_ready}, 32'd0);
    check("rst_pins", {21'd0, sr_d, sr_i, sr_l, sr_r}, 32'd0);
    @(negedge c); #1 nrst = 1'b1;
    @(posedge c); #1;
    check("rst_ready_after_release", {30'd0, busy, cmd_ready}, 32'd1);

    for (int k = 0; k < 15; k++) run_vec(vecs[k], k);

    // Back-to-back with cmd_valid held, plus a pulse while busy
    @(negedge c);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_amt = 3'd0; cmd_data = 8'h55; cmd_fill = 1'b0;
    @(posedge c); #1;
    check("b2b_first_accept", {31'd0, busy}, 32'd1);
    cmd_op = 3'd1; cmd_amt = 3'd2; cmd_fill = 1'b0;
    @(posedge c); #1;
    check("b2b_first_done", {23'd0, done, sr_q}, {23'd0, 1'b1, 8'h55});
    @(posedge c); #1;
    check("b2b_idle_gap", {30'd0, busy, cmd_ready}, 32'd1);
    @(posedge c); #1;
    check("b2b_second_accept", {31'd0, busy}, 32'd1);
    cmd_op = 3'd0; cmd_data = 8'h00;
    @(posedge c); #1;
    check("b2b_step1", {24'd0, sr_q}, 32'hAA);
    @(posedge c); #1;
    check("b2b_second_done", {23'd0, done, sr_q}, {23'd0, 1'b1, 8'h54});
    cmd_valid = 1'b0;
    @(posedge c); #1;
    @(posedge c); #1;
    check("b2b_busy_pulse_ignored", {23'd0, busy, sr_q}, {23'd0, 1'b0, 8'h54});

    // Reset in the middle of an SHR 7
    v = '{3'd0, 3'd0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1};
    run_vec(v, 100);
    @(negedge c);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd7; cmd_fill = 1'b0;
    @(posedge c); #1;
    cmd_valid = 1'b0;
    @(posedge c);
    @(posedge c); #1;
    check("mid_rst_partial", {24'd0, sr_q}, 32'h3F);
    #1 nrst = 1'b0;
    #1;
    check("mid_rst_immediate", {27'd0, sr_l, sr_r, done, busy, cmd_ready}, 32'd0);
    repeat (3) @(posedge c);
    #1;
    check("mid_rst_hold", {24'd0, sr_q}, 32'h3F);
    @(negedge c); #1 nrst = 1'b1;
    @(posedge c); #1;
    check("mid_rst_ready", {30'd0, busy, cmd_ready}, 32'd1);
    v = '{3'd0, 3'd0, 8'h11, 1'b0, 8'h11, 1'b0, 1};
    run_vec(v, 101);

    check("gated_clock_lr_stable", gc_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 8-bit universal shift register (d, i, c, l, r -> q).
- Accepts one command at a time over a valid/ready handshake: load, logical shift, rotate or arithmetic shift by 0..7.
- Drives the register's l/r/d/i pins one step per clock, reads q back for the rotate and arithmetic fill bits, and pulses done when finished.
- Sits between the datapath command source and the shift register instance.

Parameters:
- W, 8, register width; must match the shift register.
- AW, 3, width of the shift-amount field; the maximum amount is 2^AW-1.

Ports:
- c  in  1  clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6-7 illegal.
- cmd_amt  in  AW  number of shift steps; ignored for LOAD.
- cmd_data  in  W  load value.
- cmd_fill  in  1  fill bit for SHL/SHR.
- sr_q  in  W  register contents.
- sr_d  out  W  to register d.
- sr_i  out  1  to register i.
- sr_l  out  1  to register l.
- sr_r  out  1  to register r.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal op flag, valid while done=1.

Behaviour:
- Register mode encoding:
  - l=1, r=1: parallel load of d.
  - l=1, r=0: shift toward LSB; i enters the MSB.
  - l=0, r=1: shift toward MSB; i enters the LSB.
  - l=0, r=0: hold. The register gates its clock with (l|r)&c.
- Gated-clock safety:
  - sr_l, sr_r, sr_i and sr_d are registered on the falling edge of c, so they are stable while c is high.
  - sr_l and sr_r must never change while c is high.
- Main FSM states: IDLE, RUN, DONE. The FSM is rising-edge. A latch of op/amt/data/fill plus a step counter cnt (AW bits) accompany it.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at rising edge E0, latch the command.
  - LOAD: cnt=1 -> RUN.
  - Ops 1-5 with amt>0: cnt=amt -> RUN.
  - Ops 1-5 with amt=0: -> DONE.
  - Ops 6-7: -> DONE with err=1.
- RUN:
  - Each rising edge executes one register step and decrements cnt.
  - When cnt==1 at the edge, go to DONE.
- DONE:
  - done=1 and cmd_ready=0 for exactly one cycle, then IDLE.
  - err holds its value until the next accept.
- Negedge output logic (evaluated from the current state and latched op):
  - Not RUN: l=r=0; sr_d and sr_i hold.
  - LOAD: l=r=1; sr_d = latched data.
  - SHL: l=0, r=1; i = fill.
  - SHR: l=1, r=0; i = fill.
  - ROL: l=0, r=1; i = sr_q[W-1].
  - ROR: l=1, r=0; i = sr_q[0].
  - ASR: l=1, r=0; i = sr_q[W-1].
  - sr_q is sampled at the falling edge, so it reflects the previous step.
- Latency:
  - Command with n steps accepted at E0 executes at E1..En.
  - done is high for the cycle after En; cmd_ready rises at En+1.
  - amt=0 or illegal op: done is high for the cycle after E0.
- cmd_valid while busy is ignored and no command is latched; the source must hold cmd_valid until the handshake.
- Asynchronous reset, including mid-operation:
  - State=IDLE, cnt=0, done=0, err=0.
  - sr_l=sr_r=0, sr_i=0, sr_d=0 immediately; the register holds its partial result.
  - cmd_ready=1 on the first rising edge after nrst deasserts.
- busy = state != IDLE. cmd_ready = state==IDLE and nrst high.

Test Plan:
- Reset, then LOAD 0xA5 at E0 -> sr_q=0xA5 after E1; done high in the cycle after E1; err=0; cmd_ready back after E2.
- From 0xA5: SHL amt=3 fill=1 -> sr_q=0x2F after 3 steps; done one cycle; sr_l/sr_r never toggle while c is high (check every edge).
- From 0xA5: ROR amt=4 -> 0x5A. ROL amt=1 on 0x80 -> 0x01. ASR amt=2 on 0xA5 -> 0xE9. SHR amt=0 -> done the cycle after accept, q unchanged.
- Back-to-back commands with cmd_valid held high: the second command is accepted only at the edge where cmd_ready=1; no step is lost or duplicated; a cmd_valid pulse while busy is ignored.
- LOAD 0xFF, then SHR amt=7 fill=0; assert nrst after 2 steps -> sr_q stays 0x3F, sr_l=sr_r=0 immediately, done=0; after release a new LOAD 0x11 completes normally.
- Illegal op 7 with amt=3 -> done and err=1 in the cycle after accept; sr_q unchanged; next legal command clears err.
